reaction_timer_ctrl: RTL and testbench
======================================

# reaction_timer_ctrl

Parametrised reaction-timer controller for the DE10-Lite game. It holds the game state machine and generates its own millisecond tick. It produces an LFSR-based random start delay, counts the reaction time in an N-digit BCD counter and tracks the best score. The top level drives the seven-segment decoders from its digit outputs and muxes in the GO BUFFS scroller while attract mode is active.

## Interface
- `N_DIGITS`, 4: number of BCD digits; digit 0 = milliseconds.
- `TICK_DIV`, 50000: clock cycles per 1 ms tick; 50 MHz / 50000 = 1 kHz.
- `MIN_DELAY_MS`, 1000: minimum random delay in ticks.
- `DELAY_BITS`, 11: random delay span = 0 to 2^DELAY_BITS-1 ticks, added to the minimum.
- `FS_HOLD_MS`, 2000: how long the false-start indication is held, in ticks.

- `MAX10_CLK1_50` in, 1: the block's single clock; all logic on its rising edge.
- `reset_n` in, 1: asynchronous, active-low reset.
- `key_start_n` in, 1: raw start/stop button, active-low (KEY[0]).
- `key_clear_n` in, 1: raw clear/abort button, active-low (KEY[1]).
- `sw_attract` in, 1: raw attract-mode switch (SW[9]).
- `digits` out, 4*N_DIGITS: packed BCD digits; digit i is at [4i+3:4i].
- `digit_blank` out, N_DIGITS: 1 = digit i is blanked.
- `state_code` out, 3: current state encoding (drives LEDR[6:4]).
- `go_led` out, 1: high only in TIMING.
- `new_record` out, 1: one-cycle pulse when the best score improves.

## Operation
- Input conditioning:
  - All three raw inputs pass through a 2-flop synchronizer.
  - Press event = synchronized key transitions 1 to 0; one-cycle pulse.
  - There is no debounce; board keys are Schmitt-triggered.
- Tick:
  - Free-running prescaler gives a one-cycle tick every TICK_DIV cycles.
  - The prescaler is cleared on every state change.
- Random delay source:
  - LFSR: 16-bit Fibonacci, taps 16,14,13,11, seed 16'hACE1; shifts every cycle; never reaches zero.
  - On entry to DELAYING: delay_cnt = MIN_DELAY_MS + lfsr[DELAY_BITS-1:0].
- State encodings: IDLE 000, DELAYING 001, TIMING 010, DISPLAYING 011, ATTRACT 100, FALSE_START 101.
- Transitions (synchronized sw_attract has priority over everything):
  - Any state, sw_attract=1: go to ATTRACT. ATTRACT, sw_attract=0: go to IDLE.
  - IDLE: start press goes to DELAYING.
  - DELAYING:
    - Clear press goes to IDLE.
    - Start press goes to FALSE_START.
    - Tick with delay_cnt==1 goes to TIMING; the BCD counter is zeroed on entry.
  - TIMING:
    - Each tick increments the BCD counter with ripple carry.
    - At all 9s the counter saturates and holds.
    - Start press goes to DISPLAYING; score = counter.
    - Clear press goes to IDLE; the score is discarded.
  - DISPLAYING: clear press goes to IDLE; start press goes to DELAYING (replay).
  - FALSE_START: clear press, or FS_HOLD_MS ticks elapsed, goes to IDLE.
- Simultaneous events:
  - Start and clear presses in the same cycle: clear wins.
  - Start press in the same cycle as delay expiry: start wins (FALSE_START).
- Best score:
  - Reset value is all 9s.
  - On entry to DISPLAYING, if score < best (unsigned BCD compare, equal to binary compare): best = score and new_record pulses.
- Digit outputs:

  | State | `digits` | `digit_blank` |
  |---|---|---|
  | IDLE | best | 0 |
  | DELAYING | — | all 1 |
  | TIMING | live counter | 0 |
  | DISPLAYING | score | 0 |
  | FALSE_START | all 4'hE | 0 |
  | ATTRACT | — | all 1 |

## Timing
- Reset values:
  - State IDLE; `state_code`=000.
  - `digits` = all 9s (best); `digit_blank`=0.
  - `go_led`=0, `new_record`=0.
  - Score = 0, counter = 0, LFSR = seed.
- Reset is asserted asynchronously; release is sampled on the clock.
- A reset mid-game returns to IDLE and reloads the best score to all 9s.
- Key latency: raw pin falls before clock edge k, so the state change is visible after edge k+3. This is 2 synchronizer flops, 1 edge-detect flop and 1 state register.
- `digits`, `digit_blank`, `go_led` and `state_code` are registered; they update in the same cycle as the state.
- The first TIMING increment occurs exactly TICK_DIV cycles after TIMING entry.
- Measured score (ticks) = full ticks between entering TIMING and the stop press being registered.

## Configuration
- `FALSE_START_EN`: defined means FALSE_START behaves as described above.
- When the macro is undefined:
  - FALSE_START does not exist.
  - A start press during DELAYING is ignored.
  - A start press coincident with delay expiry goes to TIMING.
  - Encoding 101 is never produced.

## Test plan
All cases use TICK_DIV=4, MIN_DELAY_MS=3, DELAY_BITS=2, N_DIGITS=4, FS_HOLD_MS=5.
- Reset, then start press:
  - After reset: `state_code`=000, `digits`=16'h9999, `go_led`=0.
  - Start press: 001 three edges later, all digits blanked.
- Delay length:
  - LFSR low bits 2'b10 at DELAYING entry: 001 lasts exactly 5 ticks (20 cycles).
  - Then `go_led`=1 and `digits`=16'h0000.
- Timing run:
  - In TIMING, wait 37 ticks, then start press.
  - 011, `digits`=16'h0037, `new_record` pulses once, IDLE later shows 0037.
  - A second run scoring 0050: no `new_record`, best stays 0037.
- Saturation: remain in TIMING 10000+ ticks; `digits` holds 16'h9999.
- False start (`FALSE_START_EN` defined):
  - Start press in DELAYING: 101, `digits`=16'hEEEE, IDLE after 5 ticks.
  - Same stimulus with the macro undefined: stays 001.
- Priority:
  - `sw_attract`=1 during TIMING: 100 with all digits blanked; `sw_attract`=0 returns to 000.
  - Start and clear pressed together in DISPLAYING: IDLE.
  - `reset_n` low mid-TIMING: immediately 000, `digits`=16'h9999.

Source files
------------

// File: rtl/reaction_timer_ctrl.sv
// reaction_timer_ctrl: DE10-Lite reaction-timer game controller.
// Holds the game FSM, a ms-tick prescaler, an LFSR random start delay,
// an N-digit saturating BCD reaction counter and a best-score register.
// Optional feature macro: FALSE_START_EN (enables the FALSE_START state).
module reaction_timer_ctrl #(
    parameter int unsigned N_DIGITS     = 4,
    parameter int unsigned TICK_DIV     = 50000,
    parameter int unsigned MIN_DELAY_MS = 1000,
    parameter int unsigned DELAY_BITS   = 11,
    parameter int unsigned FS_HOLD_MS   = 2000
) (
    input  logic                  MAX10_CLK1_50,
    input  logic                  reset_n,
    input  logic                  key_start_n,
    input  logic                  key_clear_n,
    input  logic                  sw_attract,
    output logic [4*N_DIGITS-1:0] digits,
    output logic [N_DIGITS-1:0]   digit_blank,
    output logic [2:0]            state_code,
    output logic                  go_led,
    output logic                  new_record
);

    localparam int unsigned DW      = 4 * N_DIGITS;
    localparam int unsigned PW      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned DLY_MAX = MIN_DELAY_MS + (2 ** DELAY_BITS) - 1;
    localparam int unsigned CNT_MAX = (DLY_MAX > FS_HOLD_MS) ? DLY_MAX : FS_HOLD_MS;
    localparam int unsigned CW      = $clog2(CNT_MAX + 1);
    localparam logic [DW-1:0] BCD_ALL9 = {N_DIGITS{4'h9}};
    localparam logic [DW-1:0] BCD_ALLE = {N_DIGITS{4'hE}};
    localparam logic [15:0]   LFSR_SEED = 16'hACE1;

    typedef enum logic [2:0] {
        S_IDLE        = 3'b000,
        S_DELAYING    = 3'b001,
        S_TIMING      = 3'b010,
        S_DISPLAYING  = 3'b011,
        S_ATTRACT     = 3'b100,
        S_FALSE_START = 3'b101
    } state_t;

    state_t          r_state, w_next;
    logic [1:0]      r_start_sync, r_clear_sync, r_attr_sync;
    logic            r_start_prev, r_clear_prev, r_start_press, r_clear_press;
    logic [15:0]     r_lfsr;
    logic [PW-1:0]   r_presc;
    logic [CW-1:0]   r_cnt, w_cnt_nxt, w_delay_load;
    logic [DW-1:0]   r_bcd, w_bcd_nxt, w_bcd_inc;
    logic [DW-1:0]   r_score, w_score_nxt, r_best, w_best_nxt;
    logic [DW-1:0]   w_digits_nxt;
    logic [N_DIGITS-1:0] w_blank_nxt;
    logic            w_rec_nxt, w_carry;
    logic            w_start_p, w_clear_p, w_attract, w_tick;

    // Two-flop synchronizers for the raw pins
    always_ff @(posedge MAX10_CLK1_50 or negedge reset_n) begin
        if (!reset_n) begin
            r_start_sync <= 2'b11;
            r_clear_sync <= 2'b11;
            r_attr_sync  <= 2'b00;
        end else begin
            r_start_sync <= {r_start_sync[0], key_start_n};
            r_clear_sync <= {r_clear_sync[0], key_clear_n};
            r_attr_sync  <= {r_attr_sync[0], sw_attract};
        end
    end

    // Registered falling-edge detect producing one-cycle press pulses
    always_ff @(posedge MAX10_CLK1_50 or negedge reset_n) begin
        if (!reset_n) begin
            r_start_prev  <= 1'b1;
            r_clear_prev  <= 1'b1;
            r_start_press <= 1'b0;
            r_clear_press <= 1'b0;
        end else begin
            r_start_prev  <= r_start_sync[1];
            r_clear_prev  <= r_clear_sync[1];
            r_start_press <= r_start_prev & ~r_start_sync[1];
            r_clear_press <= r_clear_prev & ~r_clear_sync[1];
        end
    end

    // Clear beats start when both arrive together
    assign w_clear_p    = r_clear_press;
    assign w_start_p    = r_start_press & ~r_clear_press;
    assign w_attract    = r_attr_sync[1];
    assign w_tick       = (r_presc == PW'(TICK_DIV - 1));
    assign w_delay_load = CW'(MIN_DELAY_MS) + CW'(r_lfsr[DELAY_BITS-1:0]);

    // Fibonacci LFSR x^16+x^14+x^13+x^11+1, shifts every cycle
    always_ff @(posedge MAX10_CLK1_50 or negedge reset_n) begin
        if (!reset_n) r_lfsr <= LFSR_SEED;
        else          r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
    end

    // Millisecond prescaler, restarted on every state change
    always_ff @(posedge MAX10_CLK1_50 or negedge reset_n) begin
        if (!reset_n)                         r_presc <= '0;
        else if (w_next != r_state || w_tick) r_presc <= '0;
        else                                  r_presc <= r_presc + PW'(1);
    end

    // BCD ripple-carry increment of the live counter
    always_comb begin
        w_bcd_inc = r_bcd;
        w_carry   = 1'b1;
        for (int i = 0; i < int'(N_DIGITS); i++) begin
            if (w_carry) begin
                if (r_bcd[4*i +: 4] == 4'd9) begin
                    w_bcd_inc[4*i +: 4] = 4'd0;
                end else begin
                    w_bcd_inc[4*i +: 4] = r_bcd[4*i +: 4] + 4'd1;
                    w_carry             = 1'b0;
                end
            end
        end
    end

    // Next-state and datapath next values; attract overrides everything
    always_comb begin
        w_next      = r_state;
        w_cnt_nxt   = r_cnt;
        w_bcd_nxt   = r_bcd;
        w_score_nxt = r_score;
        w_best_nxt  = r_best;
        w_rec_nxt   = 1'b0;
        if (w_attract) begin
            w_next = S_ATTRACT;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_start_p) begin
                        w_next    = S_DELAYING;
                        w_cnt_nxt = w_delay_load;
                    end
                end
                S_DELAYING: begin
                    if (w_clear_p) begin
                        w_next = S_IDLE;
`ifdef FALSE_START_EN
                    end else if (w_start_p) begin
                        w_next    = S_FALSE_START;
                        w_cnt_nxt = CW'(FS_HOLD_MS);
`endif
                    end else if (w_tick) begin
                        if (r_cnt == CW'(1)) begin
                            w_next    = S_TIMING;
                            w_bcd_nxt = '0;
                        end else begin
                            w_cnt_nxt = r_cnt - CW'(1);
                        end
                    end
                end
                S_TIMING: begin
                    if (w_clear_p) begin
                        w_next = S_IDLE;
                    end else if (w_start_p) begin
                        w_next      = S_DISPLAYING;
                        w_score_nxt = r_bcd;
                        if (r_bcd < r_best) begin
                            w_best_nxt = r_bcd;
                            w_rec_nxt  = 1'b1;
                        end
                    end else if (w_tick && r_bcd != BCD_ALL9) begin
                        w_bcd_nxt = w_bcd_inc;
                    end
                end
                S_DISPLAYING: begin
                    if (w_clear_p) begin
                        w_next = S_IDLE;
                    end else if (w_start_p) begin
                        w_next    = S_DELAYING;
                        w_cnt_nxt = w_delay_load;
                    end
                end
`ifdef FALSE_START_EN
                S_FALSE_START: begin
                    if (w_clear_p) begin
                        w_next = S_IDLE;
                    end else if (w_tick) begin
                        if (r_cnt == CW'(1)) w_next = S_IDLE;
                        else                 w_cnt_nxt = r_cnt - CW'(1);
                    end
                end
`endif
                S_ATTRACT: w_next = S_IDLE;
                default:   w_next = S_IDLE;
            endcase
        end
    end

    // Display contents for the state being entered
    always_comb begin
        w_digits_nxt = '0;
        w_blank_nxt  = '0;
        case (w_next)
            S_IDLE:        w_digits_nxt = w_best_nxt;
            S_DELAYING:    w_blank_nxt  = '1;
            S_TIMING:      w_digits_nxt = w_bcd_nxt;
            S_DISPLAYING:  w_digits_nxt = w_score_nxt;
            S_FALSE_START: w_digits_nxt = BCD_ALLE;
            S_ATTRACT:     w_blank_nxt  = '1;
            default:       w_blank_nxt  = '1;
        endcase
    end

    // State, datapath and registered outputs
    always_ff @(posedge MAX10_CLK1_50 or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_bcd       <= '0;
            r_score     <= '0;
            r_best      <= BCD_ALL9;
            digits      <= BCD_ALL9;
            digit_blank <= '0;
            state_code  <= 3'b000;
            go_led      <= 1'b0;
            new_record  <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_cnt       <= w_cnt_nxt;
            r_bcd       <= w_bcd_nxt;
            r_score     <= w_score_nxt;
            r_best      <= w_best_nxt;
            digits      <= w_digits_nxt;
            digit_blank <= w_blank_nxt;
            state_code  <= w_next;
            go_led      <= (w_next == S_TIMING);
            new_record  <= w_rec_nxt;
        end
    end

endmodule

// File: tb/tb_reaction_timer_ctrl.sv
// Directed testbench for reaction_timer_ctrl (TICK_DIV=4, MIN_DELAY_MS=3,
// DELAY_BITS=2, N_DIGITS=4, FS_HOLD_MS=5). Inputs driven and outputs sampled
// on the falling clock edge.
module tb_reaction_timer_ctrl;

    logic        clk, reset_n, key_start_n, key_clear_n, sw_attract;
    logic [15:0] digits;
    logic [3:0]  digit_blank;
    logic [2:0]  state_code;
    logic        go_led, new_record;
    logic [15:0] m_lfsr;
    int          n_vec, n_err;

    reaction_timer_ctrl #(
        .N_DIGITS(4), .TICK_DIV(4), .MIN_DELAY_MS(3), .DELAY_BITS(2), .FS_HOLD_MS(5)
    ) dut (
        .MAX10_CLK1_50(clk), .reset_n(reset_n), .key_start_n(key_start_n),
        .key_clear_n(key_clear_n), .sw_attract(sw_attract), .digits(digits),
        .digit_blank(digit_blank), .state_code(state_code), .go_led(go_led),
        .new_record(new_record)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

    // Reference LFSR: seed on reset, one step per rising edge
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) m_lfsr <= 16'hACE1;
        else          m_lfsr <= lfsr_step(m_lfsr);
    end

    // LFSR value the DUT will use when a press driven now is registered
    function automatic logic [15:0] lfsr_at_press();
        return lfsr_step(lfsr_step(lfsr_step(m_lfsr)));
    endfunction

    // Drive a press at this falling edge; returns two falling edges later
    task automatic press(input bit st, input bit cl);
        if (st) key_start_n = 1'b0;
        if (cl) key_clear_n = 1'b0;
        repeat (2) @(negedge clk);
        key_start_n = 1'b1;
        key_clear_n = 1'b1;
    endtask

    task automatic wait_state(input logic [2:0] code, input int bound, output bit ok, output int cyc);
        cyc = 0;
        while (state_code !== code && cyc < bound) begin
            @(negedge clk);
            cyc++;
        end
        ok = (state_code === code);
    endtask

    task automatic test_reset;
        #2 reset_n = 1'b0;
        @(negedge clk);
        n_vec++; if (state_code !== 3'b000) begin n_err++; $display("FAIL reset_state got %b exp 000", state_code); end
        n_vec++; if (digits !== 16'h9999) begin n_err++; $display("FAIL reset_digits got %h exp 9999", digits); end
        n_vec++; if (digit_blank !== 4'h0) begin n_err++; $display("FAIL reset_blank got %h exp 0", digit_blank); end
        n_vec++; if (go_led !== 1'b0 || new_record !== 1'b0) begin n_err++; $display("FAIL reset_leds got go=%b rec=%b exp 0 0", go_led, new_record); end
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    // Start press with LFSR low bits 2'b10 -> 5-tick (20-cycle) delay
    task automatic test_delay;
        logic [15:0] v;
        int k;
        k = 0;
        v = lfsr_at_press();
        while (v[1:0] != 2'b10 && k < 64) begin
            @(negedge clk);
            k++;
            v = lfsr_at_press();
        end
        n_vec++; if (v[1:0] != 2'b10) begin n_err++; $display("FAIL lfsr_search got %b exp 10", v[1:0]); end
        press(1'b1, 1'b0);
        @(negedge clk);
        n_vec++; if (state_code !== 3'b000) begin n_err++; $display("FAIL start_latency_early got %b exp 000", state_code); end
        @(negedge clk);
        n_vec++; if (state_code !== 3'b001) begin n_err++; $display("FAIL start_to_delaying got %b exp 001", state_code); end
        n_vec++; if (digit_blank !== 4'hF) begin n_err++; $display("FAIL delaying_blank got %h exp F", digit_blank); end
        repeat (19) @(negedge clk);
        n_vec++; if (state_code !== 3'b001) begin n_err++; $display("FAIL delay_still_001 got %b exp 001", state_code); end
        @(negedge clk);
        n_vec++; if (state_code !== 3'b010) begin n_err++; $display("FAIL delay_end got %b exp 010", state_code); end
        n_vec++; if (go_led !== 1'b1 || digits !== 16'h0000 || digit_blank !== 4'h0) begin
            n_err++; $display("FAIL timing_entry got go=%b digits=%h blank=%h exp 1 0000 0", go_led, digits, digit_blank); end
    endtask

    // Called one falling edge after TIMING entry; stop at 37 ticks
    task automatic test_timing_run;
        repeat (146) @(negedge clk);
        press(1'b1, 1'b0);
        @(negedge clk);
        n_vec++; if (state_code !== 3'b010 || digits !== 16'h0037) begin
            n_err++; $display("FAIL live_count got state=%b digits=%h exp 010 0037", state_code, digits); end
        @(negedge clk);
        n_vec++; if (state_code !== 3'b011 || digits !== 16'h0037) begin
            n_err++; $display("FAIL score_37 got state=%b digits=%h exp 011 0037", state_code, digits); end
        n_vec++; if (new_record !== 1'b1) begin n_err++; $display("FAIL record_pulse got %b exp 1", new_record); end
        @(negedge clk);
        n_vec++; if (new_record !== 1'b0) begin n_err++; $display("FAIL record_one_cycle got %b exp 0", new_record); end
        press(1'b0, 1'b1);
        repeat (2) @(negedge clk);
        n_vec++; if (state_code !== 3'b000 || digits !== 16'h0037 || digit_blank !== 4'h0) begin
            n_err++; $display("FAIL idle_best_37 got state=%b digits=%h blank=%h exp 000 0037 0", state_code, digits, digit_blank); end
    endtask

    // Replay scoring 50: delay follows LFSR, best stays 37
    task automatic test_second_run;
        logic [15:0] v;
        bit ok;
        int cyc;
        v = lfsr_at_press();
        press(1'b1, 1'b0);
        repeat (2) @(negedge clk);
        n_vec++; if (state_code !== 3'b001) begin n_err++; $display("FAIL run2_delaying got %b exp 001", state_code); end
        wait_state(3'b010, 64, ok, cyc);
        n_vec++; if (!ok || cyc != 4 * (3 + int'(v[1:0]))) begin
            n_err++; $display("FAIL run2_delay_len got ok=%0d cycles=%0d exp %0d", ok, cyc, 4 * (3 + int'(v[1:0]))); end
        repeat (198) @(negedge clk);
        press(1'b1, 1'b0);
        repeat (2) @(negedge clk);
        n_vec++; if (state_code !== 3'b011 || digits !== 16'h0050) begin
            n_err++; $display("FAIL score_50 got state=%b digits=%h exp 011 0050", state_code, digits); end
        n_vec++; if (new_record !== 1'b0) begin n_err++; $display("FAIL no_record got %b exp 0", new_record); end
        press(1'b0, 1'b1);
        repeat (2) @(negedge clk);
        n_vec++; if (state_code !== 3'b000 || digits !== 16'h0037) begin
            n_err++; $display("FAIL best_kept_37 got state=%b digits=%h exp 000 0037", state_code, digits); end
    endtask

    // Long TIMING run saturates at 9999, then attract overrides
    task automatic test_saturation_attract;
        bit ok;
        int cyc;
        press(1'b1, 1'b0);
        wait_state(3'b010, 80, ok, cyc);
        n_vec++; if (!ok) begin n_err++; $display("FAIL sat_reach_timing got %b exp 010", state_code); end
        repeat (40020) @(negedge clk);
        n_vec++; if (state_code !== 3'b010 || digits !== 16'h9999) begin
            n_err++; $display("FAIL saturate got state=%b digits=%h exp 010 9999", state_code, digits); end
        repeat (9) @(negedge clk);
        n_vec++; if (digits !== 16'h9999) begin n_err++; $display("FAIL saturate_hold got %h exp 9999", digits); end
        sw_attract = 1'b1;
        wait_state(3'b100, 6, ok, cyc);
        n_vec++; if (!ok || digit_blank !== 4'hF || go_led !== 1'b0) begin
            n_err++; $display("FAIL attract got state=%b blank=%h go=%b exp 100 F 0", state_code, digit_blank, go_led); end
        sw_attract = 1'b0;
        wait_state(3'b000, 6, ok, cyc);
        n_vec++; if (!ok || digits !== 16'h0037 || digit_blank !== 4'h0) begin
            n_err++; $display("FAIL attract_exit got state=%b digits=%h blank=%h exp 000 0037 0", state_code, digits, digit_blank); end
    endtask

    // Second start press during DELAYING
    task automatic test_false_start;
        bit ok;
        int cyc;
        press(1'b1, 1'b0);
        repeat (2) @(negedge clk);
        n_vec++; if (state_code !== 3'b001) begin n_err++; $display("FAIL fs_delaying got %b exp 001", state_code); end
        press(1'b1, 1'b0);
        @(negedge clk);
        n_vec++; if (state_code !== 3'b001) begin n_err++; $display("FAIL fs_latency got %b exp 001", state_code); end
        @(negedge clk);
`ifdef FALSE_START_EN
        n_vec++; if (state_code !== 3'b101 || digits !== 16'hEEEE || digit_blank !== 4'h0) begin
            n_err++; $display("FAIL false_start got state=%b digits=%h blank=%h exp 101 EEEE 0", state_code, digits, digit_blank); end
        repeat (19) @(negedge clk);
        n_vec++; if (state_code !== 3'b101) begin n_err++; $display("FAIL fs_hold got %b exp 101", state_code); end
        @(negedge clk);
        n_vec++; if (state_code !== 3'b000) begin n_err++; $display("FAIL fs_to_idle got %b exp 000", state_code); end
`else
        n_vec++; if (state_code !== 3'b001) begin n_err++; $display("FAIL start_ignored got %b exp 001", state_code); end
        wait_state(3'b010, 64, ok, cyc);
        n_vec++; if (!ok) begin n_err++; $display("FAIL nofs_timing got %b exp 010", state_code); end
        press(1'b0, 1'b1);
        repeat (2) @(negedge clk);
        n_vec++; if (state_code !== 3'b000) begin n_err++; $display("FAIL clear_timing got %b exp 000", state_code); end
`endif
    endtask

    // Zero score, then start+clear together in DISPLAYING
    task automatic test_simultaneous;
        bit ok;
        int cyc;
        press(1'b1, 1'b0);
        wait_state(3'b010, 80, ok, cyc);
        n_vec++; if (!ok) begin n_err++; $display("FAIL sim_reach_timing got %b exp 010", state_code); end
        press(1'b1, 1'b0);
        repeat (2) @(negedge clk);
        n_vec++; if (state_code !== 3'b011 || digits !== 16'h0000 || new_record !== 1'b1) begin
            n_err++; $display("FAIL score_zero got state=%b digits=%h rec=%b exp 011 0000 1", state_code, digits, new_record); end
        press(1'b1, 1'b1);
        repeat (2) @(negedge clk);
        n_vec++; if (state_code !== 3'b000 || digits !== 16'h0000) begin
            n_err++; $display("FAIL clear_wins got state=%b digits=%h exp 000 0000", state_code, digits); end
    endtask

    task automatic test_reset_mid_timing;
        bit ok;
        int cyc;
        press(1'b1, 1'b0);
        wait_state(3'b010, 80, ok, cyc);
        n_vec++; if (!ok) begin n_err++; $display("FAIL rst_reach_timing got %b exp 010", state_code); end
        repeat (10) @(negedge clk);
        reset_n = 1'b0;
        #1;
        n_vec++; if (state_code !== 3'b000 || digits !== 16'h9999 || go_led !== 1'b0) begin
            n_err++; $display("FAIL async_reset got state=%b digits=%h go=%b exp 000 9999 0", state_code, digits, go_led); end
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        n_vec++; if (state_code !== 3'b000 || digits !== 16'h9999) begin
            n_err++; $display("FAIL post_reset_idle got state=%b digits=%h exp 000 9999", state_code, digits); end
    endtask

    initial begin
        n_vec       = 0;
        n_err       = 0;
        reset_n     = 1'b1;
        key_start_n = 1'b1;
        key_clear_n = 1'b1;
        sw_attract  = 1'b0;
        test_reset();
        test_delay();
        test_timing_run();
        test_second_run();
        test_saturation_attract();
        test_false_start();
        test_simultaneous();
        test_reset_mid_timing();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
